// File: rtl/alarm_controller.sv
// alarm_controller: alarm time storage, match detection and ring/snooze sequencing.
//
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous, active-high reset
//   tick_1hz_i     one-cycle 1 Hz enable pulse (same pulse that steps the seconds counter)
//   cur_hr_i       current hour (0..23)
//   cur_min_i      current minute (0..59)
//   set_mode_i     alarm-set mode; btn_hr_i/btn_min_i only act while high
//   btn_hr_i       advance alarm hour (wraps 23 -> 0)
//   btn_min_i      advance alarm minute (wraps 59 -> 0, no carry into hour)
//   alarm_en_i     alarm armed switch
//   btn_snooze_i   snooze request pulse
//   btn_stop_i     stop request pulse
//   alarm_hr_o     stored alarm hour
//   alarm_min_o    stored alarm minute
//   state_o        00 idle, 01 armed, 10 ringing, 11 snooze
//   ringing_o      high while ringing
//   buzzer_o       beep pattern, toggles once per second while ringing
module alarm_controller #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3,
    parameter int unsigned HR_W        = 5,
    parameter int unsigned MIN_W       = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             tick_1hz_i,
    input  logic [HR_W-1:0]  cur_hr_i,
    input  logic [MIN_W-1:0] cur_min_i,
    input  logic             set_mode_i,
    input  logic             btn_hr_i,
    input  logic             btn_min_i,
    input  logic             alarm_en_i,
    input  logic             btn_snooze_i,
    input  logic             btn_stop_i,
    output logic [HR_W-1:0]  alarm_hr_o,
    output logic [MIN_W-1:0] alarm_min_o,
    output logic [1:0]       state_o,
    output logic             ringing_o,
    output logic             buzzer_o
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StArmed   = 2'b01,
        StRinging = 2'b10,
        StSnooze  = 2'b11
    } state_e;

    localparam int unsigned RingW = $clog2(RING_SECS + 1);
    localparam int unsigned SnzW  = $clog2(SNOOZE_SECS + 1);
    // +2 keeps the counter at least one bit wide even when MAX_SNOOZE is 0.
    localparam int unsigned CntW  = $clog2(MAX_SNOOZE + 2);

    localparam logic [RingW-1:0] RingLast = RingW'(RING_SECS);
    localparam logic [SnzW-1:0]  SnzInit  = SnzW'(SNOOZE_SECS);
    localparam logic [SnzW-1:0]  SnzOne   = SnzW'(1);
    localparam logic [CntW-1:0]  CntMax   = CntW'(MAX_SNOOZE);
    localparam logic [HR_W-1:0]  HrMax    = HR_W'(23);
    localparam logic [MIN_W-1:0] MinMax   = MIN_W'(59);

    state_e           state_q, state_d;
    logic [HR_W-1:0]  alarm_hr_q, alarm_hr_d;
    logic [MIN_W-1:0] alarm_min_q, alarm_min_d;
    logic [RingW-1:0] ring_q, ring_d;
    logic [SnzW-1:0]  snz_q, snz_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             match_q, match_d;
    logic             ringing_q, ringing_d;
    logic             buzzer_q, buzzer_d;
    logic             trigger;

    // Alarm time setting
    always_comb begin
        alarm_hr_d  = alarm_hr_q;
        alarm_min_d = alarm_min_q;
        if (set_mode_i && btn_hr_i) begin
            alarm_hr_d = (alarm_hr_q == HrMax) ? '0 : alarm_hr_q + HR_W'(1);
        end
        if (set_mode_i && btn_min_i) begin
            alarm_min_d = (alarm_min_q == MinMax) ? '0 : alarm_min_q + MIN_W'(1);
        end
    end

    // Rising edge of the time match starts an alarm event; holding the match does not retrigger.
    always_comb begin
        match_d = (cur_hr_i == alarm_hr_q) && (cur_min_i == alarm_min_q);
        trigger = match_d && !match_q && !set_mode_i;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        cnt_d   = cnt_q;
        if (!alarm_en_i) begin
            state_d = StIdle;
            ring_d  = '0;
            snz_d   = '0;
            cnt_d   = '0;
        end else if (set_mode_i && (state_q == StRinging || state_q == StSnooze)) begin
            state_d = StArmed;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StArmed;
                end
                StArmed: begin
                    if (trigger) begin
                        state_d = StRinging;
                        ring_d  = '0;
                        cnt_d   = '0;
                    end
                end
                StRinging: begin
                    if (btn_stop_i) begin
                        state_d = StArmed;
                    end else if (btn_snooze_i && (cnt_q < CntMax)) begin
                        state_d = StSnooze;
                        snz_d   = SnzInit;
                        cnt_d   = cnt_q + CntW'(1);
                    end else if (tick_1hz_i) begin
                        ring_d = ring_q + RingW'(1);
                        if (ring_d == RingLast) begin
                            state_d = StArmed;
                        end
                    end
                end
                StSnooze: begin
                    if (btn_stop_i) begin
                        state_d = StArmed;
                    end else if (tick_1hz_i) begin
                        if (snz_q == SnzOne) begin
                            state_d = StRinging;
                            ring_d  = '0;
                        end
                        snz_d = snz_q - SnzW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_o.
    always_comb begin
        ringing_d = (state_d == StRinging);
        buzzer_d  = 1'b0;
        if (state_d == StRinging) begin
            if (state_q != StRinging) begin
                buzzer_d = 1'b1;
            end else if (tick_1hz_i) begin
                buzzer_d = !buzzer_q;
            end else begin
                buzzer_d = buzzer_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            alarm_hr_q  <= '0;
            alarm_min_q <= '0;
            ring_q      <= '0;
            snz_q       <= '0;
            cnt_q       <= '0;
            match_q     <= 1'b0;
            ringing_q   <= 1'b0;
            buzzer_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            alarm_hr_q  <= alarm_hr_d;
            alarm_min_q <= alarm_min_d;
            ring_q      <= ring_d;
            snz_q       <= snz_d;
            cnt_q       <= cnt_d;
            match_q     <= match_d;
            ringing_q   <= ringing_d;
            buzzer_q    <= buzzer_d;
        end
    end

    assign alarm_hr_o  = alarm_hr_q;
    assign alarm_min_o = alarm_min_q;
    assign state_o     = state_q;
    assign ringing_o   = ringing_q;
    assign buzzer_o    = buzzer_q;

endmodule
